// File: rtl/ex_wb_pkg.sv
// Shared widths, timeout default and state encoding for the execute/write-back stage.
package ex_wb_pkg;
  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 5;
  localparam int CNT_W_DEF       = 16;
  localparam int ACK_TIMEOUT_DEF = 15;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
endpackage

// File: rtl/ex_wb_alu.sv
// Accumulator adder: full-width sum with carry-out and zero detect.
module ex_alu
  import ex_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o,
  output logic              zero_o
);
  logic [DATA_W:0] sum_full;

  assign sum_full = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = sum_full[DATA_W-1:0];
  assign carry_o  = sum_full[DATA_W];
  assign zero_o   = (sum_full[DATA_W-1:0] == '0);
endmodule

// File: rtl/ex_wb.sv
// Execute/write-back stage: owns the accumulator and flags, issues jumps and
// performs data-memory stores with a bounded req/ack wait.
module ex_wb
  import ex_wb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              ready,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic              wresreg,
  input  logic              wmem,
  input  logic [ADDR_W-1:0] wmemaddr,
  input  logic              wpc,
  input  logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] resreg,
  output logic              carry,
  output logic              zero,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              jmp_valid,
  output logic [ADDR_W-1:0] jmp_addr,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [0:0]        state_q,    state_d;
  logic [TMO_W-1:0]  tmo_q,      tmo_d;
  logic [DATA_W-1:0] resreg_q,   resreg_d;
  logic              carry_q,    carry_d;
  logic              zero_q,     zero_d;
  logic              mem_req_q,  mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              jmp_vld_q,  jmp_vld_d;
  logic [ADDR_W-1:0] jmp_addr_q, jmp_addr_d;
  logic              err_q,      err_d;
  logic [CNT_W-1:0]  retired_q,  retired_d;

  logic [DATA_W-1:0] alu_sum;
  logic              alu_carry;
  logic              alu_zero;
  logic              accept;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (val1),
    .b_i     (val2),
    .sum_o   (alu_sum),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  assign accept = in_valid && (state_q == ST_IDLE);

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    tmo_d      = tmo_q;
    resreg_d   = resreg_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    jmp_vld_d  = 1'b0;
    jmp_addr_d = jmp_addr_q;
    err_d      = err_q;
    retired_d  = retired_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (wresreg) begin
          resreg_d = alu_sum;
          carry_d  = alu_carry;
          zero_d   = alu_zero;
        end
        if (wpc) begin
          jmp_vld_d  = 1'b1;
          jmp_addr_d = pc_o;
        end
        // A store retires only when its write completes or is abandoned.
        if (wmem) begin
          mem_req_d  = 1'b1;
          mem_addr_d = wmemaddr;
          mem_data_d = val2;
          tmo_d      = '0;
          state_d    = ST_WAIT;
        end else begin
          retired_d = retired_q + CNT_W'(1);
        end
      end
    end else begin
      // Ack is checked first so an ack on the last permitted cycle still succeeds.
      if (mem_ack) begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
        retired_d = retired_q + CNT_W'(1);
      end else if (tmo_q == TMO_LAST) begin
        mem_req_d = 1'b0;
        err_d     = 1'b1;
        state_d   = ST_IDLE;
        retired_d = retired_q + CNT_W'(1);
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled only on clk); all state uses non-blocking assignments.
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      resreg_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      jmp_vld_q  <= 1'b0;
      jmp_addr_q <= '0;
      err_q      <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      resreg_q   <= resreg_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      jmp_vld_q  <= jmp_vld_d;
      jmp_addr_q <= jmp_addr_d;
      err_q      <= err_d;
      retired_q  <= retired_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign resreg    = resreg_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign jmp_valid = jmp_vld_q;
  assign jmp_addr  = jmp_addr_q;
  assign err       = err_q;
  assign retired   = retired_q;
endmodule

// File: tb/tb_ex_wb.sv
// Scoreboard bench for ex_wb: stimulus pushes expected retire/jump/store events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ex_wb;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          ready;
  logic [DW-1:0] val1, val2;
  logic          wresreg, wmem, wpc;
  logic [AW-1:0] wmemaddr, pc_o;
  logic [DW-1:0] resreg;
  logic          carry, zero;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ack;
  logic          jmp_valid;
  logic [AW-1:0] jmp_addr;
  logic          err;
  logic [CW-1:0] retired;

  ex_wb #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
    .val1(val1), .val2(val2), .wresreg(wresreg), .wmem(wmem),
    .wmemaddr(wmemaddr), .wpc(wpc), .pc_o(pc_o), .resreg(resreg),
    .carry(carry), .zero(zero), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .jmp_valid(jmp_valid),
    .jmp_addr(jmp_addr), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] resreg;
    logic          carry;
    logic          zero;
    logic          err;
    logic [CW-1:0] retired;
  } ret_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_t;

  ret_t          ret_q[$];
  mem_t          mem_q[$];
  logic [AW-1:0] jmp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] m_res;
  logic          m_c, m_z, m_err;
  logic [CW-1:0] m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_res = '0; m_c = 1'b0; m_z = 1'b1; m_err = 1'b0; m_ret = '0;
  endtask

  task automatic push_retire();
    ret_t r;
    m_ret     = m_ret + 1'b1;
    r.resreg  = m_res;
    r.carry   = m_c;
    r.zero    = m_z;
    r.err     = m_err;
    r.retired = m_ret;
    ret_q.push_back(r);
  endtask

  task automatic issue(input logic wr, input logic wm, input logic wp,
                       input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                       input logic [AW-1:0] a, input logic [AW-1:0] pc);
    logic [DW:0] s;
    mem_t        m;
    in_valid = 1'b1; wresreg = wr; wmem = wm; wpc = wp;
    val1 = v1; val2 = v2; wmemaddr = a; pc_o = pc;
    if (wr) begin
      s     = {1'b0, v1} + {1'b0, v2};
      m_res = s[DW-1:0];
      m_c   = s[DW];
      m_z   = (s[DW-1:0] == '0);
    end
    if (wp) jmp_q.push_back(pc);
    if (wm) begin
      m.addr = a;
      m.data = v2;
      mem_q.push_back(m);
    end else begin
      push_retire();
    end
    step();
    in_valid = 1'b0; wresreg = 1'b0; wmem = 1'b0; wpc = 1'b0;
  endtask

  // Monitor: compares each retirement, jump pulse and new write request.
  logic [CW-1:0] prev_ret;
  logic          prev_req;

  always @(negedge clk) begin
    ret_t          r;
    mem_t          m;
    logic [AW-1:0] j;
    if (reset !== 1'b1) begin
      prev_ret = retired;
      prev_req = mem_req;
    end else begin
      if (retired != prev_ret) begin
        if (ret_q.size() > 0) begin
          r = ret_q.pop_front();
          check("mon_retired", retired, r.retired);
          check("mon_resreg", resreg, r.resreg);
          check("mon_carry", carry, r.carry);
          check("mon_zero", zero, r.zero);
          check("mon_err", err, r.err);
        end else begin
          check("mon_spurious_retire", retired, prev_ret);
        end
      end
      if (jmp_valid) begin
        if (jmp_q.size() > 0) begin
          j = jmp_q.pop_front();
          check("mon_jmp_addr", jmp_addr, j);
        end else begin
          check("mon_spurious_jmp", jmp_valid, 1'b0);
        end
      end
      if (mem_req && !prev_req) begin
        if (mem_q.size() > 0) begin
          m = mem_q.pop_front();
          check("mon_mem_addr", mem_addr, m.addr);
          check("mon_mem_data", mem_data, m.data);
        end else begin
          check("mon_spurious_req", mem_req, prev_req);
        end
      end
      prev_ret = retired;
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b0; in_valid = 1'b0; wresreg = 1'b0; wmem = 1'b0; wpc = 1'b0;
    val1 = '0; val2 = '0; wmemaddr = '0; pc_o = '0; mem_ack = 1'b0;
    model_reset();
    step();
    step();
    check("rst_resreg", resreg, 8'h00);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 5'h00);
    check("rst_mem_data", mem_data, 8'h00);
    check("rst_jmp_valid", jmp_valid, 1'b0);
    check("rst_jmp_addr", jmp_addr, 5'h00);
    check("rst_err", err, 1'b0);
    check("rst_retired", retired, 16'd0);
    check("rst_ready", ready, 1'b1);
    reset = 1'b1;
    step();

    // 0x00 + 0x05
    issue(1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 5'h00, 5'h00);
    check("add1_resreg", resreg, 8'h05);
    check("add1_carry", carry, 1'b0);
    check("add1_zero", zero, 1'b0);
    check("add1_retired", retired, 16'd1);

    // 0xFF + 0x01 wraps to zero with carry
    issue(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 5'h00, 5'h00);
    check("add2_resreg", resreg, 8'h00);
    check("add2_carry", carry, 1'b1);
    check("add2_zero", zero, 1'b1);
    check("add2_retired", retired, 16'd2);

    // Nop retires, flags untouched
    issue(1'b0, 1'b0, 1'b0, 8'hAA, 8'hBB, 5'h00, 5'h00);
    check("nop_retired", retired, 16'd3);
    check("nop_resreg", resreg, 8'h00);
    check("nop_carry", carry, 1'b1);

    // Stray ack while idle
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_req", mem_req, 1'b0);
    check("idle_ack_ready", ready, 1'b1);
    check("idle_ack_retired", retired, 16'd3);

    // Store with ack after three low cycles
    issue(1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 5'h1A, 5'h00);
    for (int i = 0; i < 3; i++) begin
      check("st_req", mem_req, 1'b1);
      check("st_addr", mem_addr, 5'h1A);
      check("st_data", mem_data, 8'h3C);
      check("st_ready", ready, 1'b0);
      check("st_retired_hold", retired, 16'd3);
      step();
    end
    mem_ack = 1'b1;
    push_retire();
    step();
    mem_ack = 1'b0;
    check("st_done_req", mem_req, 1'b0);
    check("st_done_ready", ready, 1'b1);
    check("st_done_retired", retired, 16'd4);

    // Jump pulse
    issue(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 5'h07);
    check("jmp_valid_hi", jmp_valid, 1'b1);
    check("jmp_addr", jmp_addr, 5'h07);
    check("jmp_retired", retired, 16'd5);
    step();
    check("jmp_valid_lo", jmp_valid, 1'b0);
    check("jmp_addr_hold", jmp_addr, 5'h07);
    check("jmp_resreg", resreg, 8'h00);
    check("jmp_carry", carry, 1'b1);
    check("jmp_zero", zero, 1'b1);

    // All three actions together, ack already high: one-cycle WAIT
    mem_ack = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 5'h02, 5'h1F);
    check("all_resreg", resreg, 8'h30);
    check("all_carry", carry, 1'b0);
    check("all_zero", zero, 1'b0);
    check("all_jmp_valid", jmp_valid, 1'b1);
    check("all_jmp_addr", jmp_addr, 5'h1F);
    check("all_req", mem_req, 1'b1);
    check("all_ready", ready, 1'b0);
    check("all_retired_hold", retired, 16'd5);
    push_retire();
    step();
    mem_ack = 1'b0;
    check("all_done_req", mem_req, 1'b0);
    check("all_done_ready", ready, 1'b1);
    check("all_done_retired", retired, 16'd6);
    check("all_done_jmp", jmp_valid, 1'b0);

    // Timeout: ack never comes
    issue(1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 5'h05, 5'h00);
    m_err = 1'b1;
    push_retire();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    check("to_wait_cycles", cnt, 15);
    check("to_err", err, 1'b1);
    check("to_ready", ready, 1'b1);
    check("to_retired", retired, 16'd7);
    issue(1'b1, 1'b0, 1'b0, 8'h02, 8'h03, 5'h00, 5'h00);
    check("to_add_resreg", resreg, 8'h05);
    check("to_err_sticky", err, 1'b1);
    check("to_add_retired", retired, 16'd8);

    // Reset in the middle of a WAIT
    issue(1'b1, 1'b0, 1'b0, 8'h30, 8'h03, 5'h00, 5'h00);
    check("mr_resreg_pre", resreg, 8'h33);
    issue(1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 5'h0C, 5'h00);
    step();
    check("mr_in_wait", mem_req, 1'b1);
    reset = 1'b0;
    step();
    check("mr_req", mem_req, 1'b0);
    check("mr_resreg", resreg, 8'h00);
    check("mr_err", err, 1'b0);
    check("mr_retired", retired, 16'd0);
    check("mr_ready", ready, 1'b1);
    check("mr_zero", zero, 1'b1);
    step();
    reset = 1'b1;
    model_reset();
    step();

    // 0x80 + 0x80 after reset
    issue(1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 5'h00, 5'h00);
    check("pr_resreg", resreg, 8'h00);
    check("pr_carry", carry, 1'b1);
    check("pr_zero", zero, 1'b1);
    check("pr_retired", retired, 16'd1);

    step();
    step();
    check("left_retire", ret_q.size(), 0);
    check("left_mem", mem_q.size(), 0);
    check("left_jmp", jmp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_wb.md
Name: ex_wb

Overview:
- Execute/write-back stage directly downstream of the decode stage of the 8-bit accumulator CPU.
- Consumes decoded operands and control (val1/val2, wmem, wresreg, wpc, addresses) and owns the accumulator register `resreg`, which feeds back to decode.
- Drives the data-memory write port with a req/ack handshake, issues jump redirects to fetch, and keeps carry/zero flags and a retired-instruction counter.
- Stalls upstream while a memory write is outstanding.

Parameters:
- DATA_W, 8, accumulator/operand width
- ADDR_W, 5, memory and PC address width
- CNT_W, 16, retired-instruction counter width
- ACK_TIMEOUT, 15, max WAIT cycles before a write is abandoned (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  decode outputs valid this cycle
- ready  out  1  stage can accept; = (state==IDLE)
- val1  in  DATA_W  operand 1
- val2  in  DATA_W  operand 2 / store data
- wresreg  in  1  write accumulator with val1+val2
- wmem  in  1  store val2 to wmemaddr
- wmemaddr  in  ADDR_W  store address
- wpc  in  1  jump request
- pc_o  in  ADDR_W  jump target
- resreg  out  DATA_W  accumulator (registered)
- carry  out  1  carry of last accumulator write
- zero  out  1  resreg==0 after last accumulator write
- mem_req  out  1  write request, held until ack
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- mem_ack  in  1  memory accepted write
- jmp_valid  out  1  one-cycle jump pulse to fetch
- jmp_addr  out  ADDR_W  jump target
- err  out  1  sticky write-timeout flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at posedge):
  - resreg=0, carry=0, zero=1, mem_req=0, mem_addr=0, mem_data=0, jmp_valid=0, jmp_addr=0, err=0, retired=0.
  - state=IDLE, timeout counter=0.
  - Reset takes priority over everything. A reset during WAIT abandons the write; mem_req is low from the next edge.
- Accept: when in_valid && ready at a posedge. Nothing changes when in_valid=0; jmp_valid deasserts every cycle it is not being pulsed.
- Accumulator (wresreg accepted):
  - sum = val1 + val2 at DATA_W+1 bits.
  - resreg<=sum[DATA_W-1:0], carry<=sum[DATA_W], zero<=(sum[DATA_W-1:0]==0).
  - Latency 1: visible the cycle after accept. Flags are unchanged when wresreg=0.
- Jump (wpc accepted): jmp_valid=1 for exactly the next cycle, with jmp_addr=pc_o; jmp_addr holds afterwards.
- Store (wmem accepted):
  - Next cycle: mem_req=1, mem_addr=wmemaddr, mem_data=val2, state=WAIT, ready=0.
  - In WAIT, req/addr/data are held stable. mem_ack is sampled each posedge.
  - On ack: mem_req<=0, state<=IDLE, retire. Earliest completion is 1 WAIT cycle, i.e. ack is already high when req first rises.
  - mem_ack in IDLE is ignored.
- Timeout: the WAIT cycle counter starts at 0. If ACK_TIMEOUT cycles pass with no ack: mem_req<=0, err<=1 (sticky until reset), state<=IDLE. The instruction still counts as retired. An ack on the final cycle wins over the timeout.
- Simultaneous flags: all accepted actions execute independently in the same accept cycle. Only wmem enters WAIT.
- Nop: all flags 0 with in_valid=1 still retires.
- retired:
  - +1 on accept of any non-wmem instruction.
  - +1 on WAIT exit (ack or timeout) for wmem.
  - Wraps modulo 2^CNT_W.
- State machine: IDLE→WAIT on accepted wmem; WAIT→IDLE on ack or timeout; any state→IDLE on reset.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W/CNT_W defaults
  - state encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1
  - default ACK_TIMEOUT
- Sub-module ex_alu (combinational): DATA_W adder producing sum, carry, zero. Everything else stays in ex_wb.

Test Plan:
- Reset, then accept wresreg val1=0x00 val2=0x05 → next cycle resreg=0x05, carry=0, zero=0, retired=1.
- wresreg val1=0xFF val2=0x01 → resreg=0x00, carry=1, zero=1.
- Store:
  - Stimulus: wmem, addr=0x1A, val2=0x3C; mem_ack held low 3 cycles, then high.
  - Required: mem_req=1, addr=0x1A, data=0x3C held stable; ready=0 throughout; mem_req=0 and ready=1 after the ack edge; retired +1 only then.
- Jump: wpc pc_o=0x07 → jmp_valid high exactly one cycle with jmp_addr=0x07; resreg, carry and zero unchanged.
- Timeout:
  - Stimulus: wmem with mem_ack never asserted, ACK_TIMEOUT=15.
  - Required: mem_req drops after 15 WAIT cycles, err=1 and stays set; a subsequent wresreg 0x02+0x03 gives resreg=0x05.
- Mid-operation reset: assert reset=0 during WAIT with resreg=0x33 → next cycle mem_req=0, resreg=0, err=0, retired=0, ready=1.
